// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and the message-controller state encoding.
package sha256_pkg;

  localparam int          SHA_BLOCK_WORDS = 16;
  localparam logic [31:0] SHA_PAD_WORD    = 32'h8000_0000;
  localparam int          SHA_LEN_HI_IDX  = 14;
  localparam int          SHA_LEN_LO_IDX  = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PAD80,
    ST_PAD_ZERO,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_WAIT_CORE
  } ShaCtrlState;

endpackage

// File: rtl/sha256_tail_pad.sv
// Masks the unused bytes of a short final message word and inserts the 0x80 marker.
// Purely combinational; nbytes of 4 or more passes the word through untouched.
module sha256_tail_pad
  import sha256_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [2:0]  nbytes_i,
  output logic [31:0] data_o
);

  always_comb begin
    case (nbytes_i)
      3'd0:    data_o = SHA_PAD_WORD;
      3'd1:    data_o = {data_i[31:24], 24'h80_0000};
      3'd2:    data_o = {data_i[31:16], 16'h8000};
      3'd3:    data_o = {data_i[31:8], 8'h80};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/sha256_msg_ctrl.sv
// SHA-256 padding sequencer: streams message words into 16-word blocks for the core.
// Zero-latency pass-through of data words; in_rdy follows blk_rdy, generated words hold until blk_rdy.
module sha256_msg_ctrl
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [2:0]  in_nbytes,
  output logic        blk_vld,
  input  logic        blk_rdy,
  output logic [31:0] blk_data,
  output logic        blk_first,
  output logic        blk_eob,
  output logic        blk_final,
  input  logic        core_done,
  output logic        msg_done,
  output logic        busy
);

  localparam logic [3:0] LAST_IDX    = 4'(SHA_BLOCK_WORDS - 1);
  localparam logic [3:0] PRE_LEN_IDX = 4'(SHA_LEN_HI_IDX - 1);
  localparam logic [3:0] LEN_LO_IDX  = 4'(SHA_LEN_LO_IDX);

  ShaCtrlState      state_q, state_d, resume_q, resume_d;
  logic [3:0]       widx_q, widx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             first_q, first_d, final_q, final_d;
  logic             busy_q, busy_d, msg_done_q, msg_done_d;

  logic [31:0]      tail_word, blk_word;
  logic [63:0]      len_64;
  logic [5:0]       add_bits;
  logic             tail_short, blk_vld_raw, in_rdy_raw, blk_xfer;
  ShaCtrlState      after_st, pad_after;

  sha256_tail_pad u_tail_pad (
    .data_i   (in_data),
    .nbytes_i (in_nbytes),
    .data_o   (tail_word)
  );

  assign len_64     = 64'(len_q);
  assign tail_short = in_last && (in_nbytes < 3'd4);
  assign add_bits   = tail_short ? {in_nbytes, 3'b000} : 6'd32;
  // Every pad word goes to LEN_HI only when the length pair still fits in this block.
  assign pad_after  = (widx_q == PRE_LEN_IDX) ? ST_LEN_HI : ST_PAD_ZERO;

  always_comb begin
    blk_vld_raw = 1'b0;
    in_rdy_raw  = 1'b0;
    blk_word    = '0;
    after_st    = state_q;
    case (state_q)
      ST_IDLE, ST_DATA: begin
        blk_vld_raw = in_vld;
        in_rdy_raw  = blk_rdy;
        blk_word    = tail_short ? tail_word : in_data;
        if (!in_last)        after_st = ST_DATA;
        else if (tail_short) after_st = pad_after;
        else                 after_st = ST_PAD80;
      end
      ST_PAD80: begin
        blk_vld_raw = 1'b1;
        blk_word    = SHA_PAD_WORD;
        after_st    = pad_after;
      end
      ST_PAD_ZERO: begin
        blk_vld_raw = 1'b1;
        after_st    = pad_after;
      end
      ST_LEN_HI: begin
        blk_vld_raw = 1'b1;
        blk_word    = len_64[63:32];
        after_st    = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        blk_vld_raw = 1'b1;
        blk_word    = len_64[31:0];
        after_st    = ST_IDLE;
      end
      default: ;
    endcase

    blk_xfer   = blk_vld_raw && blk_rdy && !rst;
    state_d    = state_q;
    resume_d   = resume_q;
    widx_d     = widx_q;
    len_d      = len_q;
    first_d    = first_q;
    final_d    = final_q;
    busy_d     = busy_q;
    msg_done_d = 1'b0;

    if (blk_xfer) begin
      if (state_q == ST_IDLE) begin
        first_d = 1'b1;
        busy_d  = 1'b1;
        len_d   = LEN_W'(add_bits);
      end else if (state_q == ST_DATA) begin
        len_d = len_q + LEN_W'(add_bits);
      end
      if (state_q == ST_LEN_LO) final_d = 1'b1;
      if (widx_q == LAST_IDX) begin
        widx_d   = '0;
        first_d  = 1'b0;
        state_d  = ST_WAIT_CORE;
        resume_d = after_st;
      end else begin
        widx_d  = widx_q + 4'd1;
        state_d = after_st;
      end
    end else if ((state_q == ST_WAIT_CORE) && core_done) begin
      if (final_q) begin
        state_d    = ST_IDLE;
        final_d    = 1'b0;
        busy_d     = 1'b0;
        msg_done_d = 1'b1;
      end else begin
        state_d = resume_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      resume_q   <= ST_IDLE;
      widx_q     <= '0;
      len_q      <= '0;
      first_q    <= 1'b0;
      final_q    <= 1'b0;
      busy_q     <= 1'b0;
      msg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      resume_q   <= resume_d;
      widx_q     <= widx_d;
      len_q      <= len_d;
      first_q    <= first_d;
      final_q    <= final_d;
      busy_q     <= busy_d;
      msg_done_q <= msg_done_d;
    end
  end

  // Handshake outputs are forced low while reset is held so nothing transfers mid-reset.
  assign blk_vld   = blk_vld_raw && !rst;
  assign in_rdy    = in_rdy_raw && !rst;
  assign blk_data  = blk_vld ? blk_word : 32'h0;
  assign blk_first = blk_vld && ((state_q == ST_IDLE) || first_q);
  assign blk_eob   = blk_vld && (widx_q == LAST_IDX);
  assign blk_final = blk_vld && (state_q == ST_LEN_LO) && (widx_q == LEN_LO_IDX);
  assign msg_done  = msg_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Bench for sha256_msg_ctrl: byte-level padding model, randomized handshakes and core responses.
module tb_sha256_msg_ctrl;

  typedef struct packed {
    logic [31:0] d;
    logic        first;
    logic        eob;
    logic        fin;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_vld = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        in_last = 1'b0;
  logic [2:0]  in_nbytes = 3'd0;
  logic        blk_rdy = 1'b0;
  logic        core_done = 1'b0;
  logic        in_rdy, blk_vld, blk_first, blk_eob, blk_final, msg_done, busy;
  logic [31:0] blk_data;

  int errors = 0;
  int checks = 0;

  int rdy_mode = 0;
  bit spur_en = 1'b0;

  rec_t got_q[$];
  int   eob_cnt = 0, md_cnt = 0;
  int   md_err = 0, stall_err = 0, rdy_err = 0, busy_err = 0, zero_err = 0;
  logic prev_stall = 1'b0, fin_pend = 1'b0, exp_md = 1'b0, in_msg = 1'b0;
  logic [31:0] prev_data = 32'h0;

  int handled = 0;
  int dly = -1;

  byte unsigned msg[$];
  rec_t exp_q[$];

  sha256_msg_ctrl #(.LEN_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .blk_vld   (blk_vld),
    .blk_rdy   (blk_rdy),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_eob   (blk_eob),
    .blk_final (blk_final),
    .core_done (core_done),
    .msg_done  (msg_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Observer: records block transfers and tracks protocol invariants.
  always @(negedge clk) begin
    rec_t r;
    if (rst) begin
      fin_pend   = 1'b0;
      exp_md     = 1'b0;
      in_msg     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (msg_done !== exp_md) md_err++;
      if (msg_done === 1'b1) begin
        md_cnt++;
        in_msg = 1'b0;
      end
      if (busy !== in_msg) busy_err++;
      if (!blk_rdy && in_rdy) rdy_err++;
      if (!blk_vld && blk_data !== 32'h0) zero_err++;
      if (prev_stall && (!blk_vld || blk_data !== prev_data)) stall_err++;
      exp_md = core_done && fin_pend;
      if (exp_md) fin_pend = 1'b0;
      if (blk_vld && blk_rdy) begin
        r.d = blk_data; r.first = blk_first; r.eob = blk_eob; r.fin = blk_final;
        got_q.push_back(r);
        if (blk_eob) eob_cnt++;
        if (blk_eob && blk_final) fin_pend = 1'b1;
      end
      if (in_vld && in_rdy) in_msg = 1'b1;
      prev_stall = blk_vld && !blk_rdy;
      prev_data  = blk_data;
    end
  end

  // Core stand-in: drives blk_rdy per mode and answers each block with a delayed core_done.
  always @(posedge clk) begin
    #1;
    core_done = 1'b0;
    case (rdy_mode)
      0:       blk_rdy = 1'b1;
      1:       blk_rdy = 1'($urandom_range(0, 1));
      2:       blk_rdy = !blk_rdy;
      default: blk_rdy = 1'b0;
    endcase
    if (rst) begin
      handled = eob_cnt;
      dly = -1;
    end else if (dly >= 0) begin
      if (dly == 0) begin
        core_done = 1'b1;
        handled++;
        dly = -1;
      end else begin
        dly--;
      end
    end else if (handled != eob_cnt) begin
      dly = $urandom_range(0, 3);
    end else if (spur_en && $urandom_range(0, 5) == 0) begin
      core_done = 1'b1;
    end
  end

  function automatic int proto_errs();
    return md_err + stall_err + rdy_err + busy_err + zero_err;
  endfunction

  // Reference: pad the byte string exactly as SHA-256 defines, then split into tagged words.
  function automatic void build_exp();
    byte unsigned p[$];
    longint unsigned bits;
    int nblk;
    rec_t r;
    exp_q.delete();
    p = msg;
    bits = longint'(msg.size()) * 8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
    nblk = p.size() / 64;
    for (int k = 0; k < p.size() / 4; k++) begin
      r.d     = {p[4*k], p[4*k+1], p[4*k+2], p[4*k+3]};
      r.first = (k < 16);
      r.eob   = (k % 16 == 15);
      r.fin   = r.eob && (k / 16 == nblk - 1);
      exp_q.push_back(r);
    end
  endfunction

  task automatic send_msg(input bit empty_tail, input int gap_pct, output bit ok);
    int n, nw, tail_nb, t, idx;
    n = msg.size();
    ok = 1'b1;
    if (n % 4 == 0 && (empty_tail || n == 0)) begin
      nw = n / 4 + 1;
      tail_nb = 0;
    end else begin
      nw = (n + 3) / 4;
      tail_nb = n - 4 * (nw - 1);
    end
    for (int w = 0; w < nw; w++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        in_vld = 1'b0;
        in_data = $urandom;
        @(posedge clk); #1;
      end
      in_vld = 1'b1;
      in_last = (w == nw - 1);
      in_nbytes = in_last ? 3'(tail_nb) : 3'($urandom_range(0, 7));
      for (int b = 0; b < 4; b++) begin
        idx = 4 * w + b;
        in_data[31-8*b -: 8] = (idx < n) ? msg[idx] : 8'($urandom);
      end
      t = 0;
      @(negedge clk);
      while (!in_rdy && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (!in_rdy) ok = 1'b0;
      @(posedge clk); #1;
      if (!ok) break;
    end
    in_vld = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_done(input int md0, output bit ok);
    int t;
    t = 0;
    while (md_cnt == md0 && t < 4000) begin
      @(posedge clk); #1;
      t++;
    end
    ok = (md_cnt != md0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rdy_mode = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_rdy, blk_vld, blk_first, blk_eob, blk_final, msg_done, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000000", {in_rdy, blk_vld, blk_first, blk_eob, blk_final, msg_done, busy});
    end
    checks++;
    if (blk_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h required 00000000", blk_data);
    end
    rdy_mode = 3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({in_rdy, blk_vld, blk_first, blk_eob, blk_final, msg_done, busy} !== 7'b0) begin
      errors++;
      $display("FAIL idle_outputs: got %b required 0000000", {in_rdy, blk_vld, blk_first, blk_eob, blk_final, msg_done, busy});
    end
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (in_rdy !== 1'b1 || blk_vld !== 1'b0) begin
      errors++;
      $display("FAIL idle_in_rdy: got in_rdy=%b blk_vld=%b required 1 0", in_rdy, blk_vld);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_padding_lengths();
    int lens[5]   = '{3, 0, 56, 64, 55};
    int nwords[5] = '{16, 16, 32, 32, 16};
    int base, md0, pe0;
    bit ok;
    rdy_mode = 0;
    spur_en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      msg.delete();
      if (c == 0) begin
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
      end else begin
        for (int i = 0; i < lens[c]; i++) msg.push_back(8'($urandom));
      end
      build_exp();
      base = got_q.size(); md0 = md_cnt; pe0 = proto_errs();
      send_msg(1'b0, 0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL len%0d_send: input not accepted within bound", lens[c]); end
      wait_done(md0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL len%0d_done: no msg_done within bound", lens[c]); end
      checks++;
      if (got_q.size() - base != nwords[c]) begin
        errors++;
        $display("FAIL len%0d_count: got %0d words required %0d", lens[c], got_q.size() - base, nwords[c]);
      end
      for (int k = 0; k < exp_q.size() && base + k < got_q.size(); k++) begin
        checks++;
        if (got_q[base+k] !== exp_q[k]) begin
          errors++;
          $display("FAIL len%0d_word%0d: got %h required %h", lens[c], k, got_q[base+k], exp_q[k]);
        end
      end
      checks++;
      if (md_cnt - md0 != 1 || proto_errs() != pe0) begin
        errors++;
        $display("FAIL len%0d_proto: got msg_done=%0d proto_errs=%0d required 1 0", lens[c], md_cnt - md0, proto_errs() - pe0);
      end
      if (got_q.size() >= base + nwords[c]) begin
        checks++;
        case (c)
          0: if (got_q[base].d !== 32'h6162_6380 || got_q[base+15].d !== 32'h18 || !got_q[base+15].fin) begin
               errors++;
               $display("FAIL abc_words: got w0=%h w15=%h fin=%b required 61626380 00000018 1", got_q[base].d, got_q[base+15].d, got_q[base+15].fin);
             end
          2: if (got_q[base+14].d !== 32'h8000_0000 || got_q[base+31].d !== 32'h1C0 || got_q[base+16].first || got_q[base+15].fin) begin
               errors++;
               $display("FAIL b56_words: got w14=%h w31=%h first16=%b fin15=%b required 80000000 000001c0 0 0", got_q[base+14].d, got_q[base+31].d, got_q[base+16].first, got_q[base+15].fin);
             end
          3: if (got_q[base+16].d !== 32'h8000_0000 || got_q[base+31].d !== 32'h200 || got_q[base+15].fin) begin
               errors++;
               $display("FAIL b64_words: got w16=%h w31=%h fin15=%b required 80000000 00000200 0", got_q[base+16].d, got_q[base+31].d, got_q[base+15].fin);
             end
          default: if (got_q[base].d !== exp_q[0].d) begin
               errors++;
               $display("FAIL len%0d_w0: got %h required %h", lens[c], got_q[base].d, exp_q[0].d);
             end
        endcase
      end
    end
  endtask

  task automatic test_backpressure();
    int lens[2] = '{20, 70};
    int base, md0, st0, rd0;
    bit ok;
    rdy_mode = 2;
    spur_en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      msg.delete();
      for (int i = 0; i < lens[c]; i++) msg.push_back(8'($urandom));
      build_exp();
      base = got_q.size(); md0 = md_cnt; st0 = stall_err; rd0 = rdy_err;
      send_msg(1'b0, 30, ok);
      wait_done(md0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL bp%0d_done: no msg_done within bound", lens[c]); end
      checks++;
      if (got_q.size() - base != exp_q.size()) begin
        errors++;
        $display("FAIL bp%0d_count: got %0d words required %0d", lens[c], got_q.size() - base, exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && base + k < got_q.size(); k++) begin
        checks++;
        if (got_q[base+k] !== exp_q[k]) begin
          errors++;
          $display("FAIL bp%0d_word%0d: got %h required %h", lens[c], k, got_q[base+k], exp_q[k]);
        end
      end
      checks++;
      if (stall_err != st0 || rdy_err != rd0) begin
        errors++;
        $display("FAIL bp%0d_stall: got stall_errs=%0d rdy_errs=%0d required 0 0", lens[c], stall_err - st0, rdy_err - rd0);
      end
    end
    rdy_mode = 0;
  endtask

  task automatic test_random_msgs();
    int n, base, md0, pe0;
    bit ok, et;
    rdy_mode = 1;
    spur_en = 1'b1;
    for (int m = 0; m < 12; m++) begin
      n = $urandom_range(0, 150);
      et = 1'($urandom_range(0, 1));
      msg.delete();
      for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
      build_exp();
      base = got_q.size(); md0 = md_cnt; pe0 = proto_errs();
      send_msg(et, 25, ok);
      wait_done(md0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rnd%0d_done: len %0d no msg_done within bound", m, n); end
      checks++;
      if (got_q.size() - base != exp_q.size()) begin
        errors++;
        $display("FAIL rnd%0d_count: len %0d got %0d words required %0d", m, n, got_q.size() - base, exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && base + k < got_q.size(); k++) begin
        checks++;
        if (got_q[base+k] !== exp_q[k]) begin
          errors++;
          $display("FAIL rnd%0d_word%0d: len %0d got %h required %h", m, k, n, got_q[base+k], exp_q[k]);
        end
      end
      checks++;
      if (md_cnt - md0 != 1 || proto_errs() != pe0) begin
        errors++;
        $display("FAIL rnd%0d_proto: got msg_done=%0d proto_errs=%0d required 1 0", m, md_cnt - md0, proto_errs() - pe0);
      end
    end
    spur_en = 1'b0;
    rdy_mode = 0;
  endtask

  task automatic test_reset_mid();
    int base, md0, t;
    bit ok;
    rdy_mode = 0;
    spur_en = 1'b0;
    msg.delete();
    for (int i = 0; i < 60; i++) msg.push_back(8'($urandom));
    base = got_q.size();
    send_msg(1'b0, 0, ok);
    t = 0;
    while (got_q.size() < base + 20 && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (got_q.size() < base + 20) begin
      errors++;
      $display("FAIL rstmid_reach: got %0d words required 20", got_q.size() - base);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({in_rdy, blk_vld, blk_first, blk_eob, blk_final, msg_done, busy} !== 7'b0 || blk_data !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %b data %h required 0000000 00000000", {in_rdy, blk_vld, blk_first, blk_eob, blk_final, msg_done, busy}, blk_data);
    end
    rdy_mode = 3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({in_rdy, blk_vld, blk_first, blk_eob, blk_final, msg_done, busy} !== 7'b0) begin
      errors++;
      $display("FAIL rstmid_idle: got %b required 0000000", {in_rdy, blk_vld, blk_first, blk_eob, blk_final, msg_done, busy});
    end
    rdy_mode = 0;
    @(posedge clk); #1;
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    build_exp();
    base = got_q.size(); md0 = md_cnt;
    send_msg(1'b0, 0, ok);
    wait_done(md0, ok);
    checks++;
    if (!ok || got_q.size() - base != 16) begin
      errors++;
      $display("FAIL rstmid_abc_count: got %0d words done=%b required 16 1", got_q.size() - base, ok);
    end
    for (int k = 0; k < exp_q.size() && base + k < got_q.size(); k++) begin
      checks++;
      if (got_q[base+k] !== exp_q[k]) begin
        errors++;
        $display("FAIL rstmid_abc_word%0d: got %h required %h", k, got_q[base+k], exp_q[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_padding_lengths();
    test_backpressure();
    test_random_msgs();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
